// File: rtl/fsm_step4_pkg.sv
// Shared constants for the memory-stage (step 4) controller: cause codes, opcodes, FSM states.
package fsm_step4_pkg;

  localparam logic [2:0] CAUSE_EXT_IRQ  = 3'b000;
  localparam logic [2:0] CAUSE_ILLEGAL  = 3'b001;
  localparam logic [2:0] CAUSE_OVF      = 3'b010;
  localparam logic [2:0] CAUSE_MISALIGN = 3'b011;
  localparam logic [2:0] CAUSE_NONE     = 3'b100;
  localparam logic [2:0] CAUSE_BUS_ERR  = 3'b101;

  localparam logic [5:0] OPCODE_NOP = 6'h00;
  localparam logic [5:0] OPCODE_LW  = 6'h23;
  localparam logic [5:0] OPCODE_SW  = 6'h2B;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } state_e;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OPCODE_LW) || (op == OPCODE_SW);
  endfunction

endpackage

// File: rtl/fsm_step4_if.sv
// Data-memory handshake between the step-4 controller (master) and the data memory (slave).
interface fsm_step4_if;
  logic mem_re;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_re, output mem_we, input mem_ready);
  modport slave  (input mem_re, input mem_we, output mem_ready);
endinterface

// File: rtl/fsm_step4_mem_timeout_counter.sv
// Saturating cycle counter for an outstanding memory access; hit_o flags MEM_TIMEOUT reached.
module fsm_step4_mem_timeout_counter #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                       cnt_d = '0;
    else if (en_i && cnt_q != LIMIT) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign hit_o = (cnt_q == LIMIT);
endmodule

// File: rtl/fsm_step4.sv
// Memory-stage control: registers step-3 state, runs the data-memory handshake, raises
// memory-stage causes, attaches pending interrupts to clean instructions, honours flush.
module fsm_step4
  import fsm_step4_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_step3,
  input  logic [5:0]        opcode_step3,
  input  logic [2:0]        cause_step3,
  input  logic [ADDR_W-1:0] epc_addr_step3,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic              ext_irq,
  input  logic              flush,
  fsm_step4_if.master       mem,
  output logic              stall,
  output logic [5:0]        opcode,
  output logic [2:0]        cause_step4,
  output logic [ADDR_W-1:0] epc_addr_step4
);
  state_e            state_q, state_d;
  logic [5:0]        opcode_q, opcode_d;
  logic [2:0]        cause_q, cause_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              irq_q, irq_d, irq_take;
  logic              cnt_clr, cnt_en, cnt_hit;
  logic              re_c, we_c, stall_c;
  logic              in_is_mem, in_aligned;
  logic              unused_addr_hi;

  assign in_is_mem      = is_mem_op(opcode_step3);
  assign in_aligned     = (alu_addr[1:0] == 2'b00);
  assign unused_addr_hi = ^alu_addr[ADDR_W-1:2];

  fsm_step4_mem_timeout_counter #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_tmo (
    .clk   (clk),
    .reset (reset),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .hit_o (cnt_hit)
  );

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    irq_take = 1'b0;
    re_c     = 1'b0;
    we_c     = 1'b0;
    stall_c  = 1'b0;
    cnt_clr  = 1'b1;
    cnt_en   = 1'b0;
    if (flush) begin
      // Squash the slot; a pending interrupt survives for the refetched stream.
      state_d  = ST_IDLE;
      opcode_d = OPCODE_NOP;
      cause_d  = CAUSE_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_step3) begin
            opcode_d = opcode_step3;
            epc_d    = epc_addr_step3;
            if (cause_step3 != CAUSE_NONE) begin
              cause_d = cause_step3;
            end else if (in_is_mem && !in_aligned) begin
              cause_d = CAUSE_MISALIGN;
            end else if (in_is_mem) begin
              cause_d = CAUSE_NONE;
              state_d = ST_WAIT_MEM;
              re_c    = (opcode_step3 == OPCODE_LW);
              we_c    = (opcode_step3 == OPCODE_SW);
              stall_c = 1'b1;
              cnt_clr = 1'b0;
              cnt_en  = 1'b1;
            end else if (irq_q) begin
              cause_d  = CAUSE_EXT_IRQ;
              irq_take = 1'b1;
            end else begin
              cause_d = CAUSE_NONE;
            end
          end else begin
            opcode_d = OPCODE_NOP;
            cause_d  = CAUSE_NONE;
          end
        end
        ST_WAIT_MEM: begin
          // Request and stall drop in the completing cycle so step 3 advances with us.
          if (mem.mem_ready) begin
            state_d = ST_IDLE;
            if (irq_q) begin
              cause_d  = CAUSE_EXT_IRQ;
              irq_take = 1'b1;
            end else begin
              cause_d = CAUSE_NONE;
            end
          end else if (cnt_hit) begin
            state_d = ST_IDLE;
            cause_d = CAUSE_BUS_ERR;
          end else begin
            re_c    = (opcode_q == OPCODE_LW);
            we_c    = (opcode_q == OPCODE_SW);
            stall_c = 1'b1;
            cnt_clr = 1'b0;
            cnt_en  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    irq_d = ext_irq | (irq_q & ~irq_take);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      opcode_q <= OPCODE_NOP;
      cause_q  <= CAUSE_NONE;
      epc_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      irq_q    <= irq_d;
    end
  end

  assign mem.mem_re     = re_c;
  assign mem.mem_we     = we_c;
  assign stall          = stall_c;
  assign opcode         = opcode_q;
  assign cause_step4    = cause_q;
  assign epc_addr_step4 = epc_q;
endmodule
